// File: rtl/qmult_pipe.sv
// Three-stage, multi-lane sign-magnitude Q-format multiplier with valid/ready flow control.
// Rounding/saturation modes travel with each beat; overflow is flagged per lane and accumulated in sticky bits.
module qmult_pipe #(
  parameter int Q     = 9,
  parameter int N     = 16,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   in_a,
  input  logic [LANES*N-1:0]   in_b,
  input  logic                 in_round,
  input  logic                 in_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   out_result,
  output logic [LANES-1:0]     out_ovr,
  output logic [LANES-1:0]     ovr_sticky,
  input  logic                 ovr_clr
);

  localparam int W1 = 2*N-2;   // raw magnitude product width
  localparam int W2 = 2*N-1;   // rounded width, leaves room for the carry
  localparam int WK = W2-Q;    // bits kept once the fraction below Q is dropped
  localparam logic [W2-1:0] HALF_ULP = {{(W2-1){1'b0}}, 1'b1} << (Q-1);

  logic                        en_s;
  logic                        v1_r, rnd1_r, sat1_r;
  logic [LANES-1:0]            sgn1_r;
  logic [LANES-1:0][W1-1:0]    mag1_r;
  logic                        v2_r, sat2_r;
  logic [LANES-1:0]            sgn2_r;
  logic [LANES-1:0][WK-1:0]    mag2_r;

  logic [LANES-1:0]            sgn_s;
  logic [LANES-1:0][W1-1:0]    prod_s;
  logic [LANES-1:0][W2-1:0]    rnd_sum_s;
  logic [LANES-1:0]            ovf_s;
  logic [LANES-1:0][N-2:0]     rmag_s;
  logic [LANES-1:0][N-1:0]     res_s;

  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;

  // Per-lane datapath: sign/product, rounding add, then overflow, saturation and -0 suppression.
  always_comb begin
    sgn_s     = '0;
    prod_s    = '0;
    rnd_sum_s = '0;
    ovf_s     = '0;
    rmag_s    = '0;
    res_s     = '0;
    for (int k = 0; k < LANES; k++) begin
      sgn_s[k]     = in_a[k*N+N-1] ^ in_b[k*N+N-1];
      prod_s[k]    = W1'(in_a[k*N +: N-1]) * W1'(in_b[k*N +: N-1]);
      rnd_sum_s[k] = {1'b0, mag1_r[k]} + (rnd1_r ? HALF_ULP : {W2{1'b0}});
      ovf_s[k]     = |mag2_r[k][WK-1:N-1];
      rmag_s[k]    = (ovf_s[k] & sat2_r) ? {(N-1){1'b1}} : mag2_r[k][N-2:0];
      res_s[k]     = {sgn2_r[k] & (rmag_s[k] != {(N-1){1'b0}}), rmag_s[k]};
    end
  end

  // Pipeline registers; every stage holds together while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r       <= 1'b0;
      rnd1_r     <= 1'b0;
      sat1_r     <= 1'b0;
      sgn1_r     <= {LANES{1'b0}};
      mag1_r     <= '0;
      v2_r       <= 1'b0;
      sat2_r     <= 1'b0;
      sgn2_r     <= {LANES{1'b0}};
      mag2_r     <= '0;
      out_valid  <= 1'b0;
      out_result <= {(LANES*N){1'b0}};
      out_ovr    <= {LANES{1'b0}};
    end else if (en_s) begin
      v1_r       <= in_valid;
      rnd1_r     <= in_round;
      sat1_r     <= in_sat;
      sgn1_r     <= sgn_s;
      mag1_r     <= prod_s;
      v2_r       <= v1_r;
      sat2_r     <= sat1_r;
      sgn2_r     <= sgn1_r;
      for (int k = 0; k < LANES; k++) begin
        mag2_r[k] <= rnd_sum_s[k][W2-1:Q];
      end
      out_valid  <= v2_r;
      out_result <= res_s;
      out_ovr    <= ovf_s;
    end else begin
      out_valid  <= out_valid;
    end
  end

  // Sticky overflow: a transferred overflowing beat sets, ovr_clr clears, set has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_sticky <= {LANES{1'b0}};
    end else begin
      ovr_sticky <= (ovr_clr ? {LANES{1'b0}} : ovr_sticky) |
                    ((out_valid & out_ready) ? out_ovr : {LANES{1'b0}});
    end
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// Directed bench for qmult_pipe (Q=9, N=16, LANES=2): hand-computed vectors, immediate-assertion checks.
module tb_qmult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_round;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_ovr;
  logic [1:0]  ovr_sticky;
  logic        ovr_clr;

  int tests = 0;
  int fails = 0;

  qmult_pipe #(.Q(9), .N(16), .LANES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_round(in_round), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovr(out_ovr),
    .ovr_sticky(ovr_sticky), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one beat, then advance two more edges so it sits on the outputs.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic rnd, input logic sat);
    in_a = a; in_b = b; in_round = rnd; in_sat = sat;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [1:0] ovr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_ovr"}, 32'(out_ovr), 32'(ovr));
  endtask

  logic [31:0] exp_q [8];
  logic [31:0] prev_res;
  logic [1:0]  prev_ovr;
  logic        stall_prev, acc, saw_drop;
  int          sent, recv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    in_round = 1'b0; in_sat = 1'b0; out_ready = 1'b1; ovr_clr = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'h0);
    check("rst_ovr", 32'(out_ovr), 32'd0);
    check("rst_sticky", 32'(ovr_sticky), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1.5 * 2.0 = 3.0 in both signs
    send_beat(32'h8300_0300, 32'h0400_0400, 1'b0, 1'b0);
    expect_out("basic", 32'h8600_0600, 2'b00);
    step();
    check("basic_drain", 32'(out_valid), 32'd0);

    // 2^-9 * 0.5: truncates to zero (no -0), rounds up to one LSB
    send_beat(32'h8001_0001, 32'h0100_0100, 1'b0, 1'b0);
    expect_out("trunc", 32'h0000_0000, 2'b00);
    step();
    send_beat(32'h8001_0001, 32'h0100_0100, 1'b1, 1'b0);
    expect_out("round", 32'h8001_0001, 2'b00);
    step();

    // 32.0 * 2.0 overflows: saturate, then wrap
    send_beat(32'h4000_4000, 32'h0400_0400, 1'b0, 1'b1);
    expect_out("sat", 32'h7FFF_7FFF, 2'b11);
    step();
    check("sat_sticky", 32'(ovr_sticky), 32'd3);
    send_beat(32'h4000_4000, 32'h0400_0400, 1'b0, 1'b0);
    expect_out("wrap", 32'h0000_0000, 2'b11);
    step();
    check("wrap_sticky", 32'(ovr_sticky), 32'd3);
    step();
    check("sticky_held", 32'(ovr_sticky), 32'd3);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("sticky_clr", 32'(ovr_sticky), 32'd0);

    send_beat(32'h7FFF_7FFF, 32'h0201_0201, 1'b1, 1'b1);
    expect_out("rnd_ovf", 32'h7FFF_7FFF, 2'b11);
    step();

    // Backpressure: 8 beats, out_ready low for cycles 4..8
    for (int i = 0; i < 8; i++) begin
      exp_q[i] = {16'h8000 | 16'((i + 1) << 9), 16'((i + 1) << 9)};
    end
    sent = 0; recv = 0; stall_prev = 1'b0; saw_drop = 1'b0;
    prev_res = 32'h0; prev_ovr = 2'b00;
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid  = (sent < 8);
      in_a      = (sent < 8) ? exp_q[sent] : 32'h0;
      in_b      = 32'h0200_0200;
      in_round  = 1'b0;
      in_sat    = 1'b0;
      out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (stall_prev) begin
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_stable_result", out_result, prev_res);
        check("bp_stable_ovr", 32'(out_ovr), 32'(prev_ovr));
      end
      if (out_valid && out_ready) begin
        if (recv < 8) begin
          check("bp_order", out_result, exp_q[recv]);
        end else begin
          check("bp_extra_beat", 32'(recv), 32'd7);
        end
        recv++;
      end
      if (!in_ready) saw_drop = 1'b1;
      acc        = in_valid & in_ready;
      stall_prev = out_valid & !out_ready;
      prev_res   = out_result;
      prev_ovr   = out_ovr;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd8);
    check("bp_recv", 32'(recv), 32'd8);
    check("bp_in_ready_drop", 32'(saw_drop), 32'd1);
    check("bp_sticky", 32'(ovr_sticky), 32'd0);

    // Reset with three overflowing beats in flight
    in_a = 32'h4000_4000; in_b = 32'h0400_0400; in_sat = 1'b1; in_round = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sticky", 32'(ovr_sticky), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check("mid_rst_sticky_after", 32'(ovr_sticky), 32'd0);

    // Clear and set in the same cycle: set wins
    send_beat(32'h4000_4000, 32'h0400_0400, 1'b0, 1'b1);
    expect_out("setclr", 32'h7FFF_7FFF, 2'b11);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("setclr_sticky", 32'(ovr_sticky), 32'd3);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("final_clr", 32'(ovr_sticky), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
